// File: rtl/lockpick_key_loader_if.sv
// Host byte stream into the lockpick key loader.
// valid/ready handshake carrying one key byte per transfer.
interface lockpick_key_loader_if;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;

  modport master (
    output host_valid,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_data,
    output host_ready
  );
endinterface

// File: rtl/lockpick_key_loader.sv
// Lockpick key loader: buffers host key bytes, starts the core,
// paces two keys per attempt and collects the core's result.
module lockpick_key_loader #(
  parameter int FIFO_DEPTH     = 8,
  parameter int KEY_BYTES      = 32,
  parameter int RESULT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_cmd_start,
  lockpick_key_loader_if.slave host,
  output logic       core_start,
  output logic       core_input_enable,
  output logic [7:0] core_input_data,
  input  logic       core_output_valid,
  input  logic [1:0] core_status,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] game_result,
  output logic [1:0] attempt_count,
  output logic       timeout_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int ATT = 2 * KEY_BYTES;
  localparam int BW  = $clog2(ATT);
  localparam int TW  = $clog2(RESULT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    WAIT_RESULT,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] wait_cnt;

  logic full, empty, push, pop, flush;
  logic last_byte, wait_expired;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = host.host_valid && !full;
  assign pop   = (state == FEED) && !empty;
  assign flush = (state != IDLE) && (state_nx == IDLE);

  assign last_byte    = (byte_cnt == BW'(ATT - 1));
  assign wait_expired = (wait_cnt == TW'(RESULT_TIMEOUT - 1));

  assign host.host_ready   = !full;
  assign core_start        = (state == START);
  assign core_input_enable = pop;
  assign core_input_data   = pop ? mem[rd_ptr] : 8'h00;
  assign busy              = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic for the attempt sequencing.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (host_cmd_start) state_nx = START;
      end
      START: state_nx = FEED;
      FEED: begin
        if (pop && last_byte) state_nx = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (core_output_valid) state_nx = DRAIN;
        else if (wait_expired) state_nx = IDLE;
      end
      DRAIN: begin
        if (!core_output_valid) begin
          state_nx = (game_result == 2'b01) ? FEED : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage; a push on a flush edge is dropped with the rest.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= host.host_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Byte pacing, result timeout and latched game status.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt      <= '0;
      wait_cnt      <= '0;
      game_result   <= 2'b00;
      result_valid  <= 1'b0;
      attempt_count <= 2'd0;
      timeout_err   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state == IDLE && host_cmd_start) begin
        attempt_count <= 2'd0;
        timeout_err   <= 1'b0;
      end
      if (pop) begin
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end
      if (state == WAIT_RESULT) begin
        if (core_output_valid) begin
          game_result  <= core_status;
          result_valid <= 1'b1;
          wait_cnt     <= '0;
          if (attempt_count != 2'd3) begin
            attempt_count <= attempt_count + 2'd1;
          end
        end else if (wait_expired) begin
          timeout_err <= 1'b1;
          wait_cnt    <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lockpick_key_loader.sv
// Bench for lockpick_key_loader: vector table, directed games
// and random games checked against a queue-based game model.
module tb_lockpick_key_loader;

  localparam int FD = 8;
  localparam int KB = 32;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_cmd_start;
  logic       core_start;
  logic       core_input_enable;
  logic [7:0] core_input_data;
  logic       core_output_valid;
  logic [1:0] core_status;
  logic       busy;
  logic       result_valid;
  logic [1:0] game_result;
  logic [1:0] attempt_count;
  logic       timeout_err;

  lockpick_key_loader_if hif ();

  lockpick_key_loader #(
    .FIFO_DEPTH(FD),
    .KEY_BYTES(KB),
    .RESULT_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_cmd_start(host_cmd_start),
    .host(hif),
    .core_start(core_start),
    .core_input_enable(core_input_enable),
    .core_input_data(core_input_data),
    .core_output_valid(core_output_valid),
    .core_status(core_status),
    .busy(busy),
    .result_valid(result_valid),
    .game_result(game_result),
    .attempt_count(attempt_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum {P_IDLE, P_START, P_FEED, P_WAIT, P_DRAIN} ph_t;

  ph_t        m_ph;
  logic [7:0] m_q[$];
  int         m_bytes, m_wait;
  logic [1:0] m_res, m_att;
  logic       m_to, m_rv;
  bit         m_known = 0;

  int         h_mode = 0;
  int         h_rate = 100;
  bit         h_seq = 0;
  logic [7:0] h_next = 8'h00;
  logic       hv_man = 1'b0;
  logic [7:0] hd_man = 8'h00;
  bit         cmd_req = 0;
  bit         rand_cmd = 0;
  bit         rst_req = 0;
  int         cyc = 0;

  int         c_cnt = 0, c_cd = 0, c_len = 0;
  int         c_lat = 3, c_hold = 2;
  bit         c_never = 0;
  logic [1:0] c_stat = 2'b00;
  logic [1:0] c_script[$];

  bit         cap_on = 0;
  logic [7:0] seen[$];
  int         rv_count = 0;

  typedef struct {
    logic       hv;
    logic [7:0] hd;
    logic       cmd;
    logic       rdy;
    logic       bsy;
    logic       st;
    logic       en;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph    = P_IDLE;
    m_q.delete();
    m_bytes = 0;
    m_wait  = 0;
    m_res   = 2'b00;
    m_att   = 2'd0;
    m_to    = 1'b0;
    m_rv    = 1'b0;
  endtask

  task automatic model_check();
    bit exp_en;
    exp_en = (m_ph == P_FEED) && (m_q.size() > 0);
    chk("host_ready", int'(hif.host_ready), int'(m_q.size() < FD));
    chk("busy", int'(busy), int'(m_ph != P_IDLE));
    chk("core_start", int'(core_start), int'(m_ph == P_START));
    chk("input_enable", int'(core_input_enable), int'(exp_en));
    chk("input_data", int'(core_input_data), exp_en ? int'(m_q[0]) : 0);
    chk("result_valid", int'(result_valid), int'(m_rv));
    chk("game_result", int'(game_result), int'(m_res));
    chk("attempt_count", int'(attempt_count), int'(m_att));
    chk("timeout_err", int'(timeout_err), int'(m_to));
  endtask

  task automatic model_step();
    ph_t was;
    bit  push, pop;
    if (rst) begin
      model_reset();
      m_known = 1;
      return;
    end
    if (!m_known) return;
    was  = m_ph;
    push = hif.host_valid && (m_q.size() < FD);
    pop  = (m_ph == P_FEED) && (m_q.size() > 0);
    m_rv = 1'b0;
    case (m_ph)
      P_IDLE: begin
        if (host_cmd_start) begin
          m_ph  = P_START;
          m_att = 2'd0;
          m_to  = 1'b0;
        end
      end
      P_START: m_ph = P_FEED;
      P_FEED: begin
        if (pop) begin
          m_bytes++;
          if (m_bytes == 2 * KB) begin
            m_bytes = 0;
            m_wait  = 0;
            m_ph    = P_WAIT;
          end
        end
      end
      P_WAIT: begin
        if (core_output_valid) begin
          m_res = core_status;
          m_rv  = 1'b1;
          if (m_att < 2'd3) m_att = m_att + 2'd1;
          m_ph  = P_DRAIN;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_to = 1'b1;
            m_ph = P_IDLE;
          end
        end
      end
      P_DRAIN: begin
        if (!core_output_valid) m_ph = (m_res == 2'b01) ? P_FEED : P_IDLE;
      end
      default: m_ph = P_IDLE;
    endcase
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(hif.host_data);
    if (was != P_IDLE && m_ph == P_IDLE) m_q.delete();
  endtask

  task automatic core_step();
    if (rst || core_start) begin
      c_cnt = 0;
      c_cd  = 0;
      c_len = 0;
      return;
    end
    if (c_len > 0) begin
      c_len--;
    end else if (c_cd > 0) begin
      c_cd--;
      if (c_cd == 0) begin
        c_len  = c_hold;
        c_stat = (c_script.size() > 0) ? c_script.pop_front()
                                       : 2'($urandom_range(1, 3));
      end
    end
    if (core_input_enable) begin
      c_cnt++;
      if (c_cnt == 2 * KB) begin
        c_cnt = 0;
        if (!c_never) c_cd = c_lat;
      end
    end
  endtask

  task automatic cycle();
    logic hv;
    @(negedge clk);
    case (h_mode)
      1:       hv = ($urandom_range(0, 99) < h_rate);
      2:       hv = (cyc % 3 == 0);
      default: hv = hv_man;
    endcase
    hif.host_valid = hv;
    if (h_mode == 0) hif.host_data = hd_man;
    else if (h_seq)  hif.host_data = h_next;
    else             hif.host_data = 8'($urandom);
    host_cmd_start = cmd_req || (rand_cmd && $urandom_range(0, 49) == 0);
    core_output_valid = (c_len > 0);
    core_status = core_output_valid ? c_stat : 2'($urandom);
    rst = rst_req;
    #1;
    if (m_known) model_check();
    if (cap_on && core_input_enable) seen.push_back(core_input_data);
    if (result_valid) rv_count++;
    model_step();
    core_step();
    if (h_seq && hif.host_valid && hif.host_ready) h_next = h_next + 8'd1;
    cmd_req = 0;
    cyc++;
  endtask

  task automatic run_until_idle(int limit);
    int n;
    bit was_busy;
    n = 0;
    was_busy = 0;
    while (n < limit) begin
      cycle();
      n++;
      if (busy) was_busy = 1;
      else if (was_busy) break;
    end
    n_tests++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL idle_wait act=%0d cycles exp=<%0d t=%0t", n, limit, $time);
    end
  endtask

  initial begin
    bit ok;
    hif.host_valid    = 1'b0;
    hif.host_data     = 8'h00;
    host_cmd_start    = 1'b0;
    core_output_valid = 1'b0;
    core_status       = 2'b00;
    rst               = 1'b1;

    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};

    rst_req = 1;
    repeat (3) cycle();
    rst_req = 0;
    cycle();
    chk("reset_ready", int'(hif.host_ready), 1);
    chk("reset_busy", int'(busy), 0);

    // Fill FIFO in IDLE, start game, see first strobes
    c_script.delete();
    c_script.push_back(2'b10);
    c_lat  = 3;
    c_hold = 3;
    cap_on = 1;
    seen.delete();
    rv_count = 0;
    for (int i = 0; i < 13; i++) begin
      h_mode  = 0;
      hv_man  = tbl[i].hv;
      hd_man  = tbl[i].hd;
      cmd_req = tbl[i].cmd;
      cycle();
      chk("tbl_ready", int'(hif.host_ready), int'(tbl[i].rdy));
      chk("tbl_busy", int'(busy), int'(tbl[i].bsy));
      chk("tbl_start", int'(core_start), int'(tbl[i].st));
      chk("tbl_en", int'(core_input_enable), int'(tbl[i].en));
      if (tbl[i].en) chk("tbl_data", int'(core_input_data), int'(tbl[i].dat));
    end
    hv_man = 1'b0;
    h_seq  = 1;
    h_next = 8'h08;
    h_mode = 1;
    h_rate = 100;
    run_until_idle(2000);
    h_mode = 0;
    h_seq  = 0;
    cap_on = 0;
    chk("win_strobes", seen.size(), 64);
    ok = 1;
    for (int i = 0; i < seen.size(); i++) if (seen[i] != 8'(i)) ok = 0;
    chk("win_order", int'(ok), 1);
    chk("win_rv_pulses", rv_count, 1);
    chk("win_result", int'(game_result), 2);
    chk("win_ready", int'(hif.host_ready), 1);
    chk("win_attempts", int'(attempt_count), 1);

    // Slow host, three errors then locked out
    c_script.delete();
    c_script.push_back(2'b01);
    c_script.push_back(2'b01);
    c_script.push_back(2'b01);
    c_script.push_back(2'b11);
    c_lat    = 3;
    c_hold   = 2;
    h_mode   = 2;
    rv_count = 0;
    cmd_req  = 1;
    run_until_idle(20000);
    h_mode = 0;
    chk("lock_rv_pulses", rv_count, 4);
    chk("lock_attempts", int'(attempt_count), 3);
    chk("lock_result", int'(game_result), 3);
    chk("lock_ready", int'(hif.host_ready), 1);

    // Random games with random host rate and core timing
    rand_cmd = 1;
    for (int g = 0; g < 6; g++) begin
      c_script.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        c_script.push_back(2'($urandom_range(1, 3)));
      end
      h_mode  = 1;
      h_rate  = $urandom_range(20, 100);
      c_lat   = $urandom_range(1, 6);
      c_hold  = $urandom_range(1, 4);
      cmd_req = 1;
      run_until_idle(20000);
    end
    rand_cmd = 0;
    if (busy || host_cmd_start) run_until_idle(20000);
    h_mode = 0;

    // Core never answers
    c_never = 1;
    h_mode  = 1;
    h_rate  = 100;
    cmd_req = 1;
    run_until_idle(2000);
    h_mode = 0;
    chk("to_flag", int'(timeout_err), 1);
    chk("to_busy", int'(busy), 0);
    cmd_req = 1;
    cycle();
    cycle();
    chk("to_cleared", int'(timeout_err), 0);
    h_mode = 2;
    repeat (30) cycle();
    chk("mid_feed_busy", int'(busy), 1);
    rst_req = 1;
    cycle();
    rst_req = 0;
    cycle();
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(core_input_enable), 0);
    chk("rst_ready", int'(hif.host_ready), 1);
    chk("rst_to", int'(timeout_err), 0);
    h_mode  = 0;
    c_never = 0;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
